move_ledger: RTL

- Parametrised successor of the game-grid marker/recorder for "vanishing-mark" tic-tac-toe variants.
- Owns the board: accepts validated moves from the game controller and tracks each player's live marks in a per-player ring FIFO.
- When a player already has DEPTH marks on the board, their oldest mark vanishes as the new one lands.
- Drives the board image to the renderer and win checker, and reports eviction, rejection and next-to-vanish information.

---
 rtl/move_ledger_pkg.sv | 20 ++
 rtl/move_ledger_pos_ring_fifo.sv | 88 ++++++++
 rtl/move_ledger.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/move_ledger_pkg.sv
// Shared encodings for the move ledger: mark codes, result codes and FSM states.
// Optional undo support is enabled elsewhere by MOVE_LEDGER_UNDO_EN.
package move_ledger_pkg;

  localparam logic [1:0] MARK_EMPTY = 2'd0;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_TURN  = 2'd1;
  localparam logic [1:0] ERR_OCC   = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  function automatic logic [1:0] mark_of(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/move_ledger_pos_ring_fifo.sv
// Per-player ring of live mark positions; front is the oldest (next to vanish).
// With MOVE_LEDGER_UNDO_EN it can also step rear/front back to revert a move.
module pos_ring_fifo #(
  parameter  int SLOTS = 3,
  parameter  int POS_W = 4,
  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int CNT_W = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
`ifdef MOVE_LEDGER_UNDO_EN
  input  logic             unpush_i,
  input  logic             unpop_i,
  output logic [POS_W-1:0] last_o,
  output logic [POS_W-1:0] prev_o,
`endif
  input  logic [POS_W-1:0] din_i,
  output logic [POS_W-1:0] peek_o,
  output logic [CNT_W-1:0] count_o
);

  logic [POS_W-1:0] mem_q [SLOTS];
  logic [PTR_W-1:0] front_q, front_d, rear_q, rear_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(SLOTS - 1) : p - 1'b1;
  endfunction

  always_comb begin
    front_d = front_q;
    rear_d  = rear_q;
    count_d = count_q;
    if (push_i) begin
      rear_d  = ptr_inc(rear_q);
      count_d = count_d + 1'b1;
    end
    if (pop_i) begin
      front_d = ptr_inc(front_q);
      count_d = count_d - 1'b1;
    end
`ifdef MOVE_LEDGER_UNDO_EN
    if (unpush_i) begin
      rear_d  = ptr_dec(rear_q);
      count_d = count_d - 1'b1;
    end
    if (unpop_i) begin
      front_d = ptr_dec(front_q);
      count_d = count_d + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      mem_q   <= '{default: '0};
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[rear_q] <= din_i;
      front_q <= front_d;
      rear_q  <= rear_d;
      count_q <= count_d;
    end
  end

  assign peek_o  = mem_q[front_q];
  assign count_o = count_q;
`ifdef MOVE_LEDGER_UNDO_EN
  // The spare slot keeps the last evicted position readable just behind front.
  assign last_o = mem_q[ptr_dec(rear_q)];
  assign prev_o = mem_q[ptr_dec(front_q)];
`endif

endmodule

// File: rtl/move_ledger.sv
// Board owner for vanishing-mark tic-tac-toe: applies moves, evicts oldest marks.
// Define MOVE_LEDGER_UNDO_EN to add the undo port and move history.
//   state     | meaning
//   ST_IDLE   | ready for a move (or undo)
//   ST_APPLY  | checks evaluated, board/FIFOs/turn updated
//   ST_REPORT | done/evict pulse for one cycle
module move_ledger
  import move_ledger_pkg::*;
#(
  parameter int CELLS   = 9,
  parameter int PLAYERS = 2,
  parameter int DEPTH   = 3,
  parameter int POS_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
`ifdef MOVE_LEDGER_UNDO_EN
  input  logic               undo,
`endif
  input  logic               mv_valid,
  output logic               mv_ready,
  input  logic [1:0]         mv_player,
  input  logic [POS_W-1:0]   mv_pos,
  output logic [CELLS*2-1:0] grid,
  output logic [1:0]         turn,
  output logic               done_valid,
  output logic               done_ok,
  output logic [1:0]         done_err,
  output logic               evict_valid,
  output logic [POS_W-1:0]   evict_pos,
  output logic               fade_valid,
  output logic [POS_W-1:0]   fade_pos
);

`ifdef MOVE_LEDGER_UNDO_EN
  localparam int SLOTS  = DEPTH + 1;
  localparam int HIST_N = PLAYERS * DEPTH;
  localparam int HCNT_W = $clog2(HIST_N + 1);
`else
  localparam int SLOTS  = DEPTH;
`endif
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam logic [POS_W:0] CELLS_L = (POS_W + 1)'(CELLS);

  logic [1:0]         state_q, state_d, turn_q, turn_d, pl_q, pl_d, err_q, err_d;
  logic [POS_W-1:0]   pos_q, pos_d, evpos_q, evpos_d;
  logic               ok_q, ok_d, ev_q, ev_d;
  logic [CELLS*2-1:0] grid_q, grid_d;

  logic [PLAYERS-1:0] push, pop;
  logic [POS_W-1:0]   peek_w [PLAYERS];
  logic [CNT_W-1:0]   cnt_w  [PLAYERS];
  logic [1:0]         cell_cur, set_mark;
  logic [CNT_W-1:0]   pl_cnt, turn_cnt;
  logic [POS_W-1:0]   pl_peek, turn_peek, set_pos, clr_pos;
  logic               set_cell, clr_cell;

`ifdef MOVE_LEDGER_UNDO_EN
  logic               undo_q, undo_d;
  logic [HIST_N-1:0]  hist_q, hist_d;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic [PLAYERS-1:0] unpush, unpop;
  logic [POS_W-1:0]   last_w [PLAYERS];
  logic [POS_W-1:0]   prev_w [PLAYERS];
  logic [POS_W-1:0]   up_last, up_prev;
  logic [1:0]         turn_back;
`endif

  for (genvar p = 0; p < PLAYERS; p++) begin : g_fifo
    pos_ring_fifo #(.SLOTS(SLOTS), .POS_W(POS_W)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clear),
      .push_i   (push[p]),
      .pop_i    (pop[p]),
`ifdef MOVE_LEDGER_UNDO_EN
      .unpush_i (unpush[p]),
      .unpop_i  (unpop[p]),
      .last_o   (last_w[p]),
      .prev_o   (prev_w[p]),
`endif
      .din_i    (pos_q),
      .peek_o   (peek_w[p]),
      .count_o  (cnt_w[p])
    );
  end

  always_comb begin
    cell_cur = MARK_EMPTY;
    for (int i = 0; i < CELLS; i++)
      if (pos_q == POS_W'(i)) cell_cur = grid_q[2*i +: 2];
    pl_cnt = '0; pl_peek = '0; turn_cnt = '0; turn_peek = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (pl_q == 2'(p))   begin pl_cnt = cnt_w[p];   pl_peek = peek_w[p];   end
      if (turn_q == 2'(p)) begin turn_cnt = cnt_w[p]; turn_peek = peek_w[p]; end
    end
`ifdef MOVE_LEDGER_UNDO_EN
    turn_back = (turn_q == 2'd0) ? 2'(PLAYERS - 1) : turn_q - 2'd1;
    up_last = '0; up_prev = '0;
    for (int p = 0; p < PLAYERS; p++)
      if (turn_back == 2'(p)) begin up_last = last_w[p]; up_prev = prev_w[p]; end
`endif
  end

  always_comb begin
    state_d = state_q; turn_d = turn_q; pl_d = pl_q; pos_d = pos_q;
    ok_d = ok_q; err_d = err_q; ev_d = ev_q; evpos_d = evpos_q;
    set_cell = 1'b0; set_pos = pos_q; set_mark = mark_of(pl_q);
    clr_cell = 1'b0; clr_pos = pl_peek;
    push = '0; pop = '0;
`ifdef MOVE_LEDGER_UNDO_EN
    undo_d = undo_q; hist_d = hist_q; hcnt_d = hcnt_q; unpush = '0; unpop = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mv_valid) begin
          pl_d    = mv_player;
          pos_d   = mv_pos;
          state_d = ST_APPLY;
        end
`ifdef MOVE_LEDGER_UNDO_EN
        undo_d = undo;
        if (undo) state_d = ST_APPLY;
`endif
      end
      ST_APPLY: begin
        state_d = ST_REPORT;
        ok_d    = 1'b0;
        ev_d    = 1'b0;
        evpos_d = '0;
`ifdef MOVE_LEDGER_UNDO_EN
        if (undo_q) begin
          err_d = ERR_NONE;
          if (hcnt_q != '0) begin
            ok_d     = 1'b1;
            turn_d   = turn_back;
            clr_cell = 1'b1;
            clr_pos  = up_last;
            for (int p = 0; p < PLAYERS; p++)
              if (turn_back == 2'(p)) begin
                unpush[p] = 1'b1;
                unpop[p]  = hist_q[0];
              end
            // An evicting move is reverted by bringing the vanished mark back.
            if (hist_q[0]) begin
              set_cell = 1'b1;
              set_pos  = up_prev;
              set_mark = mark_of(turn_back);
            end
            hist_d = hist_q >> 1;
            hcnt_d = hcnt_q - 1'b1;
          end
        end else
`endif
        if ({1'b0, pos_q} >= CELLS_L) err_d = ERR_RANGE;
        else if (pl_q != turn_q)      err_d = ERR_TURN;
        else if (cell_cur != MARK_EMPTY) err_d = ERR_OCC;
        else begin
          ok_d     = 1'b1;
          err_d    = ERR_NONE;
          set_cell = 1'b1;
          ev_d     = (pl_cnt == CNT_W'(DEPTH));
          clr_cell = ev_d;
          if (ev_d) evpos_d = pl_peek;
          for (int p = 0; p < PLAYERS; p++)
            if (pl_q == 2'(p)) begin
              push[p] = 1'b1;
              pop[p]  = ev_d;
            end
          turn_d = (turn_q == 2'(PLAYERS - 1)) ? 2'd0 : turn_q + 2'd1;
`ifdef MOVE_LEDGER_UNDO_EN
          hist_d = {hist_q[HIST_N-2:0], ev_d};
          if (hcnt_q != HCNT_W'(HIST_N)) hcnt_d = hcnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    grid_d = grid_q;
    for (int i = 0; i < CELLS; i++) begin
      if (clr_cell && clr_pos == POS_W'(i)) grid_d[2*i +: 2] = MARK_EMPTY;
      if (set_cell && set_pos == POS_W'(i)) grid_d[2*i +: 2] = set_mark;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      state_q <= ST_IDLE; turn_q <= '0; pl_q <= '0; pos_q <= '0; grid_q <= '0;
      ok_q <= 1'b0; err_q <= ERR_NONE; ev_q <= 1'b0; evpos_q <= '0;
`ifdef MOVE_LEDGER_UNDO_EN
      undo_q <= 1'b0; hist_q <= '0; hcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d; turn_q <= turn_d; pl_q <= pl_d; pos_q <= pos_d; grid_q <= grid_d;
      ok_q <= ok_d; err_q <= err_d; ev_q <= ev_d; evpos_q <= evpos_d;
`ifdef MOVE_LEDGER_UNDO_EN
      undo_q <= undo_d; hist_q <= hist_d; hcnt_q <= hcnt_d;
`endif
    end
  end

  assign mv_ready    = (state_q == ST_IDLE);
  assign done_valid  = (state_q == ST_REPORT);
  assign done_ok     = done_valid & ok_q;
  assign done_err    = done_valid ? err_q : ERR_NONE;
  assign evict_valid = done_valid & ev_q;
  assign evict_pos   = evict_valid ? evpos_q : '0;
  assign grid        = grid_q;
  assign turn        = turn_q;
  assign fade_valid  = (turn_cnt == CNT_W'(DEPTH));
  assign fade_pos    = turn_peek;

endmodule
